// File: rtl/sprite_motion_sched.sv
// sprite_motion_sched: per-frame sprite position/bounce updater and line-start pulse generator
module sprite_motion_sched #(
  parameter int CORDW      = 12,
  parameter int NSPR       = 4,
  parameter int IDW        = 2,
  parameter int H_RES      = 1920,
  parameter int V_RES      = 1080,
  parameter int V_RES_FULL = 1125,
  parameter int SPR_W      = 144,
  parameter int SPR_H      = 144,
  parameter int SPDW       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CORDW-1:0]      sx,
  input  logic [CORDW-1:0]      sy,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [IDW-1:0]        cfg_id,
  input  logic [CORDW-1:0]      cfg_x,
  input  logic [CORDW-1:0]      cfg_y,
  input  logic [SPDW-1:0]       cfg_vx,
  input  logic [SPDW-1:0]       cfg_vy,
  input  logic                  cfg_dx,
  input  logic                  cfg_dy,
  output logic [NSPR*CORDW-1:0] sprx,
  output logic [NSPR*CORDW-1:0] spry,
  output logic [NSPR-1:0]       spr_start,
  output logic                  busy
);
  localparam int W = CORDW + SPDW + 2;
  typedef enum logic {IDLE, UPDATE} state_t;
  state_t state, state_n;
  logic [IDW-1:0] idx, idx_n;
  logic [CORDW-1:0] x [NSPR];
  logic [CORDW-1:0] y [NSPR];
  logic [SPDW-1:0] vx [NSPR];
  logic [SPDW-1:0] vy [NSPR];
  logic [NSPR-1:0] dx, dy;
  logic animate, wr;
  assign animate = sy == CORDW'(V_RES) && sx == '0;
  assign cfg_ready = rst_n && state == IDLE && !animate;
  assign wr = cfg_valid && cfg_ready && 32'(cfg_id) < NSPR;
  assign busy = state == UPDATE;
  // One axis step: returns {new_dir, new_pos}; comparisons are widened so nothing wraps.
  function automatic logic [CORDW:0] step(input logic [CORDW-1:0] p, input logic [SPDW-1:0] v,
                                          input logic d, input int lim);
    logic nd;
    nd = d ? W'(p) >= W'(v) : W'(p) + W'(v) >= W'(lim);
    return {nd, nd ? p - CORDW'(v) : p + CORDW'(v)};
  endfunction
  // FSM state and sprite index registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end
  // Next state: enter UPDATE on animate, leave after the last sprite
  always_comb begin
    state_n = state == IDLE ? (animate ? UPDATE : IDLE) : (idx == IDW'(NSPR-1) ? IDLE : UPDATE);
    idx_n   = state == IDLE ? '0 : idx + 1'b1;
  end
  // Sprite state: config writes, or one sprite's motion step per UPDATE cycle
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSPR; i++) begin
      if (!rst_n) begin
        x[i]  <= '0;
        y[i]  <= '0;
        vx[i] <= '0;
        vy[i] <= '0;
        dx[i] <= 1'b0;
        dy[i] <= 1'b0;
      end else if (wr && cfg_id == IDW'(i)) begin
        x[i]  <= cfg_x;
        y[i]  <= cfg_y;
        vx[i] <= cfg_vx;
        vy[i] <= cfg_vy;
        dx[i] <= cfg_dx;
        dy[i] <= cfg_dy;
      end else if (busy && idx == IDW'(i)) begin
        {dx[i], x[i]} <= step(x[i], vx[i], dx[i], H_RES - SPR_W);
        {dy[i], y[i]} <= step(y[i], vy[i], dy[i], V_RES - SPR_H);
      end
    end
  end
  // Start pulse in the hblank of the line before each sprite's first line
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSPR; i++)
      spr_start[i] <= rst_n && sx == CORDW'(H_RES) &&
                      sy == (y[i] == '0 ? CORDW'(V_RES_FULL-1) : y[i] - 1'b1);
  end
  for (genvar g = 0; g < NSPR; g++) begin : g_pack
    assign sprx[g*CORDW +: CORDW] = x[g];
    assign spry[g*CORDW +: CORDW] = y[g];
  end
endmodule

// File: tb/tb_sprite_motion_sched.sv
// tb_sprite_motion_sched: directed table-driven checks of motion, bounce, start pulses and handshake
module tb_sprite_motion_sched;
  logic clk = 1'b0;
  logic rst_n;
  logic [11:0] sx, sy;
  logic cfg_valid, cfg_ready;
  logic [2:0] cfg_id;
  logic [11:0] cfg_x, cfg_y;
  logic [7:0] cfg_vx, cfg_vy;
  logic cfg_dx, cfg_dy;
  logic [47:0] sprx, spry;
  logic [3:0] spr_start;
  logic busy;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int id, x, y, vx, vy, dx, dy, x1, y1, x2, y2;
  } vec_t;
  vec_t tv[7];

  sprite_motion_sched #(.IDW(3)) dut (
    .clk(clk), .rst_n(rst_n), .sx(sx), .sy(sy),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_id(cfg_id),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_vx(cfg_vx), .cfg_vy(cfg_vy),
    .cfg_dx(cfg_dx), .cfg_dy(cfg_dy),
    .sprx(sprx), .spry(spry), .spr_start(spr_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] px(input int i);
    return 64'(sprx[i*12 +: 12]);
  endfunction

  function automatic logic [63:0] py(input int i);
    return 64'(spry[i*12 +: 12]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int id, x, y, vx, vy, dx, dy);
    int k;
    cfg_id = 3'(id); cfg_x = 12'(x); cfg_y = 12'(y);
    cfg_vx = 8'(vx); cfg_vy = 8'(vy); cfg_dx = 1'(dx); cfg_dy = 1'(dy);
    cfg_valid = 1'b1;
    #1;
    k = 0;
    while (!cfg_ready && k < 50) begin
      tick();
      k++;
    end
    if (k == 50) chk("cfg_ready_timeout", 64'(cfg_ready), 64'd1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic run_frame(output int nb);
    sy = 12'd1080; sx = 12'd0; nb = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (busy) nb++;
      sx = 12'(k);
    end
    sy = 12'd0; sx = 12'd0;
    #1;
  endtask

  task automatic sweep(output int c0, l0, c1, l1);
    c0 = 0; l0 = -2; c1 = 0; l1 = -2;
    for (int l = 0; l < 1125; l++) begin
      sy = 12'(l); sx = 12'd0;
      tick();
      if (spr_start[0]) begin c0++; l0 = -1; end
      if (spr_start[1]) begin c1++; l1 = -1; end
      sx = 12'd1920;
      tick();
      if (spr_start[0]) begin c0++; l0 = l; end
      if (spr_start[1]) begin c1++; l1 = l; end
    end
    sy = 12'd0; sx = 12'd0;
    tick();
    if (spr_start[0]) c0++;
    if (spr_start[1]) c1++;
  endtask

  initial begin
    int nb, c0, l0, c1, l1;
    tv[0] = '{0, 888, 468, 12, 0, 0, 0, 900, 468, 912, 468};
    tv[1] = '{1, 1764, 100, 12, 0, 0, 0, 1752, 100, 1740, 100};
    tv[2] = '{2, 5, 200, 12, 0, 1, 0, 17, 200, 29, 200};
    tv[3] = '{3, 300, 930, 0, 6, 0, 0, 300, 924, 300, 918};
    tv[4] = '{0, 0, 3, 0, 5, 0, 1, 0, 8, 0, 13};
    tv[5] = '{1, 2000, 1000, 10, 4, 0, 0, 1990, 996, 1980, 992};
    tv[6] = '{2, 1800, 0, 0, 0, 0, 1, 1800, 0, 1800, 0};
    rst_n = 1'b0; cfg_valid = 1'b1; cfg_id = '0; cfg_x = 12'd55; cfg_y = 12'd66;
    cfg_vx = '0; cfg_vy = '0; cfg_dx = 1'b0; cfg_dy = 1'b0; sx = '0; sy = '0;
    repeat (3) tick();
    chk("rst_sprx", 64'(sprx), 64'd0);
    chk("rst_spry", 64'(spry), 64'd0);
    chk("rst_start", 64'(spr_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(cfg_ready), 64'd0);
    cfg_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("idle_ready", 64'(cfg_ready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      cfg(tv[i].id, tv[i].x, tv[i].y, tv[i].vx, tv[i].vy, tv[i].dx, tv[i].dy);
      chk($sformatf("v%0d_wr_x", i), px(tv[i].id), 64'(tv[i].x));
      run_frame(nb);
      chk($sformatf("v%0d_busy_cycles", i), 64'(nb), 64'd4);
      chk($sformatf("v%0d_x1", i), px(tv[i].id), 64'(tv[i].x1));
      chk($sformatf("v%0d_y1", i), py(tv[i].id), 64'(tv[i].y1));
      run_frame(nb);
      chk($sformatf("v%0d_x2", i), px(tv[i].id), 64'(tv[i].x2));
      chk($sformatf("v%0d_y2", i), py(tv[i].id), 64'(tv[i].y2));
    end

    cfg(3, 100, 200, 0, 0, 0, 0);
    sy = 12'd1080; sx = 12'd0;
    cfg_id = 3'd3; cfg_x = 12'd777; cfg_y = 12'd555; cfg_vx = '0; cfg_vy = '0;
    cfg_dx = 1'b0; cfg_dy = 1'b0; cfg_valid = 1'b1;
    #1;
    chk("stall_animate_ready", 64'(cfg_ready), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("stall_busy_%0d", k), 64'(busy), 64'd1);
      sx = 12'(k);
      #1;
      chk($sformatf("stall_ready_%0d", k), 64'(cfg_ready), 64'd0);
    end
    tick();
    chk("stall_idle_ready", 64'(cfg_ready), 64'd1);
    chk("stall_x_held", px(3), 64'd100);
    tick();
    cfg_valid = 1'b0;
    chk("stall_x_landed", px(3), 64'd777);
    chk("stall_y_landed", py(3), 64'd555);
    sy = '0; sx = '0;

    cfg(0, 10, 20, 0, 0, 0, 0);
    cfg(1, 30, 40, 0, 0, 0, 0);
    cfg(2, 50, 60, 0, 0, 0, 0);
    cfg(5, 1, 1, 1, 1, 1, 1);
    chk("badid_sprx", 64'(sprx), {16'd0, 12'd777, 12'd50, 12'd30, 12'd10});
    chk("badid_spry", 64'(spry), {16'd0, 12'd555, 12'd60, 12'd40, 12'd20});

    cfg(0, 100, 0, 0, 0, 0, 0);
    cfg(1, 100, 500, 0, 0, 0, 0);
    sweep(c0, l0, c1, l1);
    chk("wrap_count0", 64'(c0), 64'd1);
    chk("wrap_line0", 64'(l0), 64'd1124);
    chk("y500_count1", 64'(c1), 64'd1);
    chk("y500_line1", 64'(l1), 64'd499);
    cfg(0, 100, 468, 0, 0, 0, 0);
    cfg(1, 200, 468, 0, 0, 0, 0);
    sweep(c0, l0, c1, l1);
    chk("y468_count0", 64'(c0), 64'd1);
    chk("y468_line0", 64'(l0), 64'd467);
    chk("same_count1", 64'(c1), 64'd1);
    chk("same_line1", 64'(l1), 64'd467);

    cfg(1, 123, 456, 3, 3, 0, 0);
    sy = 12'd1080; sx = 12'd0;
    tick();
    sx = 12'd1;
    tick();
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_sprx", 64'(sprx), 64'd0);
    chk("midrst_spry", 64'(spry), 64'd0);
    chk("midrst_ready", 64'(cfg_ready), 64'd0);
    tick();
    rst_n = 1'b1; sy = '0; sx = '0;
    #1;
    chk("midrst_release_ready", 64'(cfg_ready), 64'd1);
    tick();
    chk("midrst_idle_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
